key_command_encoder: RTL and testbench
======================================

Name: key_command_encoder

Overview:
- Parametrised successor to the level-only priority encoder that turns held direction keys into a game command code.
- Converts N raw key levels from the keyboard decoder into one-cycle command pulses and a compatible level code for GameControl.
- Adds an input synchroniser, a selectable priority mode, and per-key auto-repeat (initial delay, then fixed rate).
- Sits between KeyboardControl and GameControl; all logic runs in the single system clock domain.

Parameters:
N_KEYS, 4, number of key inputs; index 0 is highest fixed priority (default order: down, left, right, up).
CODE_W, 3, width of the command code.
KEY_CODES, {3'b111,3'b110,3'b101,3'b100}, flat N_KEYS*CODE_W vector; slice i is the code for key i. No slice may equal 0.
SYNC_STAGES, 2, flip-flop stages on key_in (0 allowed).
PRIORITY_MODE, 0, 0 = fixed (lowest index wins); 1 = most-recently-pressed wins.
REPEAT_MASK, 4'b0111, bit i = 1 means key i auto-repeats.
REPEAT_DELAY, 25_000_000, cycles from first pulse to first repeat pulse; must be >= 1.
REPEAT_RATE, 5_000_000, cycles between repeat pulses; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_in  input  N_KEYS  raw key levels, 1 = held
cmd_valid  output  1  one-cycle pulse, a command is issued
cmd_code  output  CODE_W  code of the last issued command; holds between pulses
cmd_level  output  CODE_W  code of the currently selected key, 0 when none is held
cmd_repeat  output  1  qualifies cmd_valid: 1 = auto-repeat pulse, 0 = fresh press

Behaviour:
- Reset: rst is sampled on the clk edge. All outputs go to 0. The sync chain, the previous-key register, the counter and the FSM (IDLE) are cleared.
- After reset is released with a key still held, the key counts as a new press and produces a pulse.
- Sync: key_s = key_in delayed by SYNC_STAGES cycles.
- Rising edges are detected against the registered key_s.
- Selection, PRIORITY_MODE 0: sel = lowest set index of key_s.
- Selection, PRIORITY_MODE 1: sel = the key with the newest rising edge.
  - Simultaneous rising edges: the lowest index wins.
  - If the selected key is released while others are held, fall back to the lowest held index. This is a selection change.
- cmd_level is registered: KEY_CODES[sel], or 0 if no key is held.
- FSM states: IDLE, DELAY, REPEAT, HOLD. A single counter of width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) serves all timed states.
- IDLE, key selected: pulse (cmd_repeat = 0), load cmd_code, counter := 0. Go to DELAY if REPEAT_MASK[sel], else HOLD.
- DELAY: counter increments. When counter == REPEAT_DELAY-1: repeat pulse (cmd_repeat = 1), counter := 0, go to REPEAT.
- REPEAT: when counter == REPEAT_RATE-1: repeat pulse, counter := 0; otherwise increment.
- HOLD: no pulses while the selection is unchanged.
- Selection changes to a different key (any non-IDLE state): fresh pulse for the new key in that cycle, counter := 0, next state chosen by REPEAT_MASK as from IDLE.
- All keys released: go to IDLE with no pulse. cmd_level becomes 0 in the same cycle; cmd_code holds its value.
- Release and press of a different key in the same cycle is treated as a selection change (pulse).
- Latency: key_in high at edge t gives cmd_valid high after edge t+SYNC_STAGES+1. cmd_level updates in the same cycle.
- At most one pulse per cycle. A pulse is never emitted in a cycle with rst high.

Decomposition:
- Shared package (tetris_pkg): command code constants CMD_NONE=0, CMD_DOWN=4, CMD_LEFT=5, CMD_RIGHT=6, CMD_ROTATE=7; the FSM state enum; the default KEY_CODES concatenation.
- One natural sub-module: key_sync_edge (SYNC_STAGES chain plus registered previous value).
  - Outputs key_s and rise.
  - Reused later for the space/reset key path.

Test Plan:
Use SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_RATE=4 and default codes unless noted.
- Press key1 (left) at cycle 0 and hold 40 cycles -> pulse code 5 at cycle 3 with cmd_repeat=0; repeat pulses at 13, 17, 21, …; cmd_level=5 from cycle 3 until 3 cycles after release.
- Hold key3 (up, non-repeating) for 50 cycles -> exactly one pulse, code 7; FSM sits in HOLD; no further pulses.
- PRIORITY_MODE 0: hold key2, then press key0 at cycle 20 -> fresh pulse code 4 at cycle 23 and the repeat timer restarts; releasing key0 -> fresh pulse code 6.
- PRIORITY_MODE 1: hold key0, press key2 at cycle 20 -> pulse code 6; press key1 and key3 in the same cycle -> key1 wins, code 5.
- Assert rst for 1 cycle while key1 is in REPEAT -> all outputs 0 during reset; a fresh pulse (cmd_repeat=0) follows 3 cycles after rst falls.
- Release all keys exactly on a REPEAT terminal-count cycle -> no pulse; cmd_level=0; cmd_code retains 5.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the game input path.
// Holds the command code constants, the key_command_encoder FSM state enum
// and the default key-to-code map.
// The map lists key 0 in the least significant slice:
// key 0 = down, key 1 = left, key 2 = right, key 3 = up (rotate).
package tetris_pkg;

   localparam logic [2:0] CMD_NONE   = 3'd0;
   localparam logic [2:0] CMD_DOWN   = 3'd4;
   localparam logic [2:0] CMD_LEFT   = 3'd5;
   localparam logic [2:0] CMD_RIGHT  = 3'd6;
   localparam logic [2:0] CMD_ROTATE = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_HOLD
   } kce_state_t;

   localparam logic [11:0] KEY_CODES_DEFAULT = {CMD_ROTATE, CMD_RIGHT, CMD_LEFT, CMD_DOWN};

endpackage

// File: rtl/key_sync_edge.sv
// Key level synchroniser with rising-edge detection.
// Ports:
//   clk     : system clock
//   rst     : synchronous, active-high reset; clears the chain and history
//   key_in  : raw key levels (DATA_W bits, 1 = held)
//   key_s   : key_in delayed by SYNC_STAGES flops (combinational when 0)
//   rise    : key_s high now but low in the previous cycle
module key_sync_edge #(
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] key_in,
   output logic [DATA_W-1:0] key_s,
   output logic [DATA_W-1:0] rise
);

   logic [DATA_W-1:0] key_prev_p1;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign key_s = key_in;
      end else begin : g_sync
         logic [DATA_W-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= key_in;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end

         assign key_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // history stage: previous key_s for edge detection
   always_ff @(posedge clk) begin
      if (rst) key_prev_p1 <= '0;
      else     key_prev_p1 <= key_s;
   end

   assign rise = key_s & ~key_prev_p1;

endmodule

// File: rtl/key_command_encoder.sv
// Turns held key levels into one-cycle command pulses with auto-repeat,
// plus a level code of the currently selected key.
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset; all outputs go to 0
//   key_in     : raw key levels, 1 = held (index 0 = highest fixed priority)
//   cmd_valid  : one-cycle pulse, a command is issued
//   cmd_code   : code of the last issued command, holds between pulses
//   cmd_level  : code of the currently selected key, 0 when none held
//   cmd_repeat : qualifies cmd_valid, 1 = auto-repeat, 0 = fresh press
module key_command_encoder
   import tetris_pkg::*;
#(
   parameter int                         N_KEYS        = 4,
   parameter int                         CODE_W        = 3,
   parameter logic [N_KEYS*CODE_W-1:0]   KEY_CODES     = KEY_CODES_DEFAULT,
   parameter int                         SYNC_STAGES   = 2,
   parameter int                         PRIORITY_MODE = 0,
   parameter logic [N_KEYS-1:0]          REPEAT_MASK   = 4'b0111,
   parameter int                         REPEAT_DELAY  = 25_000_000,
   parameter int                         REPEAT_RATE   = 5_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic              cmd_valid,
   output logic [CODE_W-1:0] cmd_code,
   output logic [CODE_W-1:0] cmd_level,
   output logic              cmd_repeat
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SEL_W   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

   logic [N_KEYS-1:0] key_s;
   logic [N_KEYS-1:0] rise;

   kce_state_t        state_p0, state_p1;
   logic [CNT_W-1:0]  cnt_p0,   cnt_p1;
   logic [SEL_W-1:0]  sel_p0,   sel_nx,  sel_p1;
   logic              any_p0;
   logic              vld_p0;
   logic              rep_p0;
   logic [CODE_W-1:0] code_p0;
   logic [CODE_W-1:0] level_p0;

   function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_KEYS-1:0] v);
      lowest_idx = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = SEL_W'(i);
      end
   endfunction

   function automatic logic [CODE_W-1:0] code_of(input logic [SEL_W-1:0] s);
      code_of = KEY_CODES[int'(s)*CODE_W +: CODE_W];
   endfunction

   key_sync_edge #(
      .DATA_W      (N_KEYS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .key_s  (key_s),
      .rise   (rise)
   );

   // stage p0: key selection
   always_comb begin
      any_p0 = |key_s;
      sel_p0 = lowest_idx(key_s);
      if (PRIORITY_MODE != 0) begin
         // Newest press wins; keep the current key while it stays held,
         // otherwise fall back to the lowest held index.
         if (|rise)
            sel_p0 = lowest_idx(rise);
         else if (state_p1 != ST_IDLE && key_s[sel_p1])
            sel_p0 = sel_p1;
      end
   end

   // stage p0: command FSM next state and pulse generation
   always_comb begin
      state_p0 = state_p1;
      cnt_p0   = cnt_p1;
      sel_nx   = sel_p1;
      vld_p0   = 1'b0;
      rep_p0   = 1'b0;
      code_p0  = cmd_code;
      level_p0 = any_p0 ? code_of(sel_p0) : CODE_W'(CMD_NONE);

      if (!any_p0) begin
         // release wins over a terminal count in the same cycle
         state_p0 = ST_IDLE;
         cnt_p0   = '0;
      end else if (state_p1 == ST_IDLE || sel_p0 != sel_p1) begin
         vld_p0   = 1'b1;
         code_p0  = code_of(sel_p0);
         cnt_p0   = '0;
         sel_nx   = sel_p0;
         state_p0 = REPEAT_MASK[sel_p0] ? ST_DELAY : ST_HOLD;
      end else begin
         case (state_p1)
            ST_DELAY: begin
               if (cnt_p1 == CNT_W'(REPEAT_DELAY - 1)) begin
                  vld_p0   = 1'b1;
                  rep_p0   = 1'b1;
                  cnt_p0   = '0;
                  state_p0 = ST_REPEAT;
               end else begin
                  cnt_p0 = cnt_p1 + CNT_W'(1);
               end
            end
            ST_REPEAT: begin
               if (cnt_p1 == CNT_W'(REPEAT_RATE - 1)) begin
                  vld_p0 = 1'b1;
                  rep_p0 = 1'b1;
                  cnt_p0 = '0;
               end else begin
                  cnt_p0 = cnt_p1 + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // stage p1: registered state and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1   <= ST_IDLE;
         cnt_p1     <= '0;
         sel_p1     <= '0;
         cmd_valid  <= 1'b0;
         cmd_repeat <= 1'b0;
         cmd_code   <= '0;
         cmd_level  <= '0;
      end else begin
         state_p1   <= state_p0;
         cnt_p1     <= cnt_p0;
         sel_p1     <= sel_nx;
         cmd_valid  <= vld_p0;
         cmd_repeat <= rep_p0;
         cmd_code   <= code_p0;
         cmd_level  <= level_p0;
      end
   end

endmodule

// File: tb/tb_key_command_encoder.sv
module tb_key_command_encoder;
   import tetris_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_a = '0;
   logic [3:0] key_b = '0;

   logic       cmd_valid_a, cmd_repeat_a;
   logic [2:0] cmd_code_a, cmd_level_a;
   logic       cmd_valid_b, cmd_repeat_b;
   logic [2:0] cmd_code_b, cmd_level_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [2:0] code;
      logic       rep;
   } pulse_t;

   typedef struct {
      logic [3:0] key;
      int         hold;
      int         code;
      logic       rep_en;
   } vec_t;

   pulse_t qa[$];
   pulse_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_command_encoder #(
      .SYNC_STAGES   (2),
      .PRIORITY_MODE (0),
      .REPEAT_DELAY  (10),
      .REPEAT_RATE   (4)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_a),
      .cmd_valid  (cmd_valid_a),
      .cmd_code   (cmd_code_a),
      .cmd_level  (cmd_level_a),
      .cmd_repeat (cmd_repeat_a)
   );

   key_command_encoder #(
      .SYNC_STAGES   (2),
      .PRIORITY_MODE (1),
      .REPEAT_DELAY  (10),
      .REPEAT_RATE   (4)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_b),
      .cmd_valid  (cmd_valid_b),
      .cmd_code   (cmd_code_b),
      .cmd_level  (cmd_level_b),
      .cmd_repeat (cmd_repeat_b)
   );

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int which, input int c, input int code, input int rep);
      pulse_t p;
      p.cyc  = c;
      p.code = code[2:0];
      p.rep  = rep[0];
      if (which == 0) qa.push_back(p);
      else            qb.push_back(p);
   endtask

   task automatic pop_check(input int which, input logic [2:0] code, input logic rep);
      pulse_t p;
      string  n;
      n = (which == 0) ? "a" : "b";
      if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected pulse: got code %0d rep %0d at cycle %0d, expected none",
                  n, code, rep, cyc);
      end else begin
         p = (which == 0) ? qa.pop_front() : qb.pop_front();
         check({n, " pulse cycle"}, cyc, p.cyc);
         check({n, " pulse code"}, int'(code), int'(p.code));
         check({n, " pulse repeat"}, int'(rep), int'(p.rep));
      end
   endtask

   // scoreboard: every observed pulse is matched against the expected queue
   always @(negedge clk) begin
      if (cmd_valid_a) pop_check(0, cmd_code_a, cmd_repeat_a);
      if (cmd_valid_b) pop_check(1, cmd_code_b, cmd_repeat_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic queues_empty(input string tag);
      check({tag, " a missing pulses"}, qa.size(), 0);
      check({tag, " b missing pulses"}, qb.size(), 0);
   endtask

   task automatic gap();
      for (int i = 0; i < 6; i++) step();
   endtask

   // single key pressed on both DUTs and held for v.hold cycles
   task automatic run_vec(input vec_t v, input int idx);
      int    t0;
      string tag;
      tag = $sformatf("vec%0d", idx);
      step();
      t0    = cyc;
      key_a = v.key;
      key_b = v.key;
      for (int w = 0; w < 2; w++) begin
         push(w, t0 + 3, v.code, 0);
         if (v.rep_en)
            for (int r = t0 + 13; r <= t0 + v.hold + 2; r += 4) push(w, r, v.code, 1);
      end
      for (int i = 1; i <= v.hold + 6; i++) begin
         step();
         if (i == v.hold) begin
            key_a = '0;
            key_b = '0;
         end
         if (i == 3 || i == v.hold + 2) begin
            check({tag, " a level held"}, cmd_level_a, v.code);
            check({tag, " b level held"}, cmd_level_b, v.code);
         end
         if (i == v.hold + 3) begin
            check({tag, " a level released"}, cmd_level_a, 0);
            check({tag, " b level released"}, cmd_level_b, 0);
         end
         if (i == v.hold + 5) begin
            check({tag, " a code retained"}, cmd_code_a, v.code);
            check({tag, " b code retained"}, cmd_code_b, v.code);
         end
      end
      queues_empty(tag);
   endtask

   initial begin
      vec_t tbl[5];
      int   t0;

      tbl[0] = '{key: 4'b0010, hold: 40, code: 5, rep_en: 1'b1};  // left, repeating
      tbl[1] = '{key: 4'b1000, hold: 50, code: 7, rep_en: 1'b0};  // up, single pulse
      tbl[2] = '{key: 4'b0001, hold: 14, code: 4, rep_en: 1'b1};  // down
      tbl[3] = '{key: 4'b0100, hold: 22, code: 6, rep_en: 1'b1};  // right
      tbl[4] = '{key: 4'b0010, hold: 18, code: 5, rep_en: 1'b1};  // release on terminal count

      // reset state
      for (int i = 0; i < 3; i++) step();
      check("reset a valid", cmd_valid_a, 0);
      check("reset a code", cmd_code_a, 0);
      check("reset a level", cmd_level_a, 0);
      check("reset a repeat", cmd_repeat_a, 0);
      check("reset b valid", cmd_valid_b, 0);
      check("reset b code", cmd_code_b, 0);
      check("reset b level", cmd_level_b, 0);
      check("reset b repeat", cmd_repeat_b, 0);
      rst = 1'b0;
      gap();

      for (int k = 0; k < 5; k++) begin
         run_vec(tbl[k], k);
         gap();
      end

      // fixed priority: key2 held, key0 overrides, then falls back to key2
      step();
      t0    = cyc;
      key_a = 4'b0100;
      push(0, t0 + 3, 6, 0);
      push(0, t0 + 13, 6, 1);
      push(0, t0 + 17, 6, 1);
      push(0, t0 + 21, 6, 1);
      push(0, t0 + 23, 4, 0);
      push(0, t0 + 33, 6, 0);
      for (int i = 1; i <= 46; i++) begin
         step();
         if (i == 20) key_a = 4'b0101;
         if (i == 30) key_a = 4'b0100;
         if (i == 40) key_a = 4'b0000;
         if (i == 25) check("fixed level override", cmd_level_a, 4);
         if (i == 35) check("fixed level fallback", cmd_level_a, 6);
         if (i == 45) begin
            check("fixed level idle", cmd_level_a, 0);
            check("fixed code retained", cmd_code_a, 6);
         end
      end
      queues_empty("fixed");
      gap();

      // same stimulus on both: key0, then key2, then key1+key3 together
      step();
      t0    = cyc;
      key_a = 4'b0001;
      key_b = 4'b0001;
      push(0, t0 + 3, 4, 0);
      for (int r = t0 + 13; r <= t0 + 41; r += 4) push(0, r, 4, 1);
      push(1, t0 + 3, 4, 0);
      push(1, t0 + 13, 4, 1);
      push(1, t0 + 17, 4, 1);
      push(1, t0 + 21, 4, 1);
      push(1, t0 + 23, 6, 0);
      push(1, t0 + 33, 5, 0);
      for (int i = 1; i <= 46; i++) begin
         step();
         if (i == 20) begin key_a = 4'b0101; key_b = 4'b0101; end
         if (i == 30) begin key_a = 4'b1111; key_b = 4'b1111; end
         if (i == 40) begin key_a = 4'b0000; key_b = 4'b0000; end
         if (i == 25) begin
            check("prio a level key0", cmd_level_a, 4);
            check("recent b level key2", cmd_level_b, 6);
         end
         if (i == 35) begin
            check("prio a level key0 late", cmd_level_a, 4);
            check("recent b level key1", cmd_level_b, 5);
         end
         if (i == 45) begin
            check("prio a code retained", cmd_code_a, 4);
            check("recent b code retained", cmd_code_b, 5);
            check("recent b level idle", cmd_level_b, 0);
         end
      end
      queues_empty("prio");
      gap();

      // reset pulse while key1 is in auto-repeat
      step();
      t0    = cyc;
      key_a = 4'b0010;
      key_b = 4'b0010;
      for (int w = 0; w < 2; w++) begin
         push(w, t0 + 3, 5, 0);
         push(w, t0 + 13, 5, 1);
         push(w, t0 + 19, 5, 0);
         push(w, t0 + 29, 5, 1);
      end
      for (int i = 1; i <= 36; i++) begin
         step();
         if (i == 15) rst = 1'b1;
         if (i == 16) begin
            check("rst a valid", cmd_valid_a, 0);
            check("rst a code", cmd_code_a, 0);
            check("rst a level", cmd_level_a, 0);
            check("rst b code", cmd_code_b, 0);
            check("rst b level", cmd_level_b, 0);
            rst = 1'b0;
         end
         if (i == 30) begin key_a = '0; key_b = '0; end
         if (i == 19) check("post-rst a level", cmd_level_a, 5);
      end
      queues_empty("rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
